coeff_bus_master: RTL
=====================

# coeff_bus_master

Initiator side of the FIR coefficient/SRAM command bus consumed by the transposed-filter controller. Accepts a stream of 40 signed 16-bit coefficients over a valid/ready handshake and sequences the update-flag/chip-select/write-enable protocol that loads them into the four 10-entry coefficient banks. After loading, it issues a 10-cycle read burst (address 0..9) on every 300 kHz sample strobe, which drives the controller's accumulate/sum phases.

## Interface
- P_NUM_COEFF, 40, total coefficients per update (4 banks x P_BANK_DEPTH)
- P_BANK_DEPTH, 10, entries per bank; read-burst length
- iClk_12M  input  1  system clock; all logic on rising edge
- iRst  input  1  reset, synchronous, active-high
- iEnSample_300k  input  1  one-cycle sample strobe
- iStartUpdate  input  1  one-cycle request to (re)load coefficients
- iCoeffValid  input  1  coefficient stream valid
- iCoeffData  input  16  signed coefficient, two's complement
- oCoeffReady  output  1  coefficient accepted when iCoeffValid & oCoeffReady
- oCoeffiUpdateFlag  output  1  update-mode flag to controller
- oCsnRam  output  1  chip select, active-low
- oWrnRam  output  1  write enable, active-low
- oAddrRam  output  4  bank address 0..9
- oWrDtRam  output  16  write data
- oNumOfCoeff  output  6  global coefficient index 0..39 (selects bank)
- oBusy  output  1  update sequence in progress
- oUpdateDone  output  1  one-cycle pulse when update completes
- oOverrun  output  1  one-cycle pulse when a sample strobe is dropped

## Operation
- All outputs registered. Reset values: oCsnRam=1, oWrnRam=1, oCoeffiUpdateFlag=0, oAddrRam=0, oWrDtRam=0, oNumOfCoeff=0, oCoeffReady=0, oBusy=0, oUpdateDone=0, oOverrun=0; state IDLE, coefficient counter 0, pending-update latch 0.
- States and bus encoding (flag/csn/wrn):
  - IDLE (0/1/1): no valid coefficients; sample strobes ignored, no overrun. iStartUpdate -> UPD_SETUP.
  - UPD_SETUP (1/1/0), 1 cycle: returns controller from sum phase to idle; harmless if already idle. -> UPD_WRITE, counter=0.
  - UPD_WRITE: oCoeffReady=1. On accept: drive 1/0/0, oWrDtRam=iCoeffData, oNumOfCoeff=counter, oAddrRam=counter mod 10, counter++. Stall (no valid): drive 1/1/0, hold oWrDtRam/oNumOfCoeff/oAddrRam (idempotent rewrite of last entry). After accept of index 39 -> UPD_END.
  - UPD_END (0/1/1), 1 cycle: oUpdateDone=1, oCoeffReady=0. -> RUN_WAIT.
  - RUN_WAIT (0/1/1): iEnSample_300k -> RUN_READ, address 0.
  - RUN_READ (0/0/1), exactly 10 cycles, oAddrRam 0,1,..,9; oWrDtRam=0, oNumOfCoeff=0. -> RUN_WAIT.
- oBusy=1 in UPD_SETUP, UPD_WRITE, UPD_END.
- Counter wraps only by restart: every update writes exactly indices 0..39 in order; oAddrRam = index mod 10, bank = index div 10.
- Simultaneous/boundary events:
  - iStartUpdate during UPD_*: ignored.
  - iStartUpdate during RUN_READ: latched pending; burst completes, then UPD_SETUP directly (no RUN_WAIT cycle). Pending cleared on entry.
  - iStartUpdate in RUN_WAIT coinciding with iEnSample_300k: update wins; strobe dropped with oOverrun=1.
  - iEnSample_300k during RUN_READ or UPD_*: dropped, oOverrun=1 next cycle.
  - iRst at any cycle: next cycle all outputs at reset values, partial load discarded; coefficients must be reloaded.

## Timing
- iStartUpdate at cycle t (IDLE/RUN_WAIT) -> UPD_SETUP outputs at t+1, oCoeffReady=1 from t+2.
- Accept at cycle t -> write command visible at t+1. Zero-stall load: 40 accepts t+2..t+41, last write at t+42, UPD_END (oUpdateDone) at t+43, RUN_WAIT at t+44.
- iEnSample_300k at t in RUN_WAIT -> addr 0 at t+1, addr 9 at t+10, oCsnRam=1 at t+11. Minimum strobe spacing 11 cycles; 40 cycles available at 12 MHz/300 kHz.

## Test plan
- Reset then load 40 coefficients 0x0001..0x0028 with valid held high -> 40 write cycles, index k carries data k+1, addr k mod 10, oUpdateDone one pulse at t+43.
- Load with iCoeffValid toggling every other cycle -> stall cycles show 1/1/0 with held addr/data, no skipped or duplicated index, 40 accepts total.
- After load, strobe -> 10-cycle read burst addr 0..9, csn=0 wrn=1, then csn=1; second strobe 5 cycles into burst -> dropped, oOverrun pulse, burst unaffected.
- iStartUpdate at read-burst addr 4 -> burst finishes addr 9, next cycle UPD_SETUP (1/1/0), full reload follows.
- iRst asserted at coefficient 20 -> next cycle reset values, IDLE; strobes ignored until a fresh update completes.
- Strobe in IDLE before any load -> no bus activity, oOverrun stays 0.

Source files
------------

// File: rtl/coeff_bus_master_if.sv
// Coefficient stream and SRAM command bus between coeff_bus_master and the filter controller.
// The master modport is the initiator side; slave is the stream source / controller side.
interface coeff_bus_master_if;
  logic        iEnSample_300k;
  logic        iStartUpdate;
  logic        iCoeffValid;
  logic [15:0] iCoeffData;
  logic        oCoeffReady;
  logic        oCoeffiUpdateFlag;
  logic        oCsnRam;
  logic        oWrnRam;
  logic [3:0]  oAddrRam;
  logic [15:0] oWrDtRam;
  logic [5:0]  oNumOfCoeff;
  logic        oBusy;
  logic        oUpdateDone;
  logic        oOverrun;

  modport master (
    input  iEnSample_300k, iStartUpdate, iCoeffValid, iCoeffData,
    output oCoeffReady, oCoeffiUpdateFlag, oCsnRam, oWrnRam, oAddrRam, oWrDtRam,
    output oNumOfCoeff, oBusy, oUpdateDone, oOverrun
  );

  modport slave (
    output iEnSample_300k, iStartUpdate, iCoeffValid, iCoeffData,
    input  oCoeffReady, oCoeffiUpdateFlag, oCsnRam, oWrnRam, oAddrRam, oWrDtRam,
    input  oNumOfCoeff, oBusy, oUpdateDone, oOverrun
  );
endinterface

// File: rtl/coeff_bus_master.sv
// Loads 40 coefficients into the four coefficient banks, then issues a 10-cycle read
// burst on every sample strobe. All bus outputs are registered.
module coeff_bus_master #(
  parameter int unsigned P_NUM_COEFF  = 40,
  parameter int unsigned P_BANK_DEPTH = 10
) (
  input logic                iClk_12M,
  input logic                iRst,
  coeff_bus_master_if.master bus
);

  localparam logic [5:0] LastIdx  = 6'(P_NUM_COEFF - 1);
  localparam logic [3:0] LastAddr = 4'(P_BANK_DEPTH - 1);

  // StUpdLast shows the final write after the last accept, with ready already low.
  typedef enum logic [2:0] {
    StIdle, StUpdSetup, StUpdWrite, StUpdLast, StUpdEnd, StRunWait, StRunRead
  } state_e;

  state_e      state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [3:0]  sub_q, sub_d;
  logic        pend_q, pend_d;
  logic        ready_q, ready_d;
  logic        flag_q, flag_d;
  logic        csn_q, csn_d;
  logic        wrn_q, wrn_d;
  logic [3:0]  addr_q, addr_d;
  logic [15:0] data_q, data_d;
  logic [5:0]  num_q, num_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        ovr_q, ovr_d;
  logic        accept;

  assign accept = bus.iCoeffValid & ready_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sub_d   = sub_q;
    pend_d  = pend_q;
    ready_d = 1'b0;
    flag_d  = 1'b0;
    csn_d   = 1'b1;
    wrn_d   = 1'b1;
    addr_d  = '0;
    data_d  = '0;
    num_d   = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    ovr_d   = bus.iEnSample_300k &
              ((state_q inside {StUpdSetup, StUpdWrite, StUpdLast, StUpdEnd, StRunRead}) |
               ((state_q == StRunWait) & bus.iStartUpdate));

    unique case (state_q)
      StIdle:     if (bus.iStartUpdate) state_d = StUpdSetup;
      StUpdSetup: state_d = StUpdWrite;
      StUpdWrite: begin
        if (accept) begin
          idx_d = idx_q + 6'd1;
          sub_d = (sub_q == LastAddr) ? '0 : sub_q + 4'd1;
          if (idx_q == LastIdx) state_d = StUpdLast;
        end
      end
      StUpdLast:  state_d = StUpdEnd;
      StUpdEnd:   state_d = StRunWait;
      StRunWait: begin
        if (bus.iStartUpdate)        state_d = StUpdSetup;
        else if (bus.iEnSample_300k) state_d = StRunRead;
      end
      StRunRead: begin
        pend_d = pend_q | bus.iStartUpdate;
        if (addr_q == LastAddr) state_d = (pend_q | bus.iStartUpdate) ? StUpdSetup : StRunWait;
      end
      default:    state_d = StIdle;
    endcase

    if (state_d == StUpdSetup) begin
      pend_d = 1'b0;
      idx_d  = '0;
      sub_d  = '0;
    end

    // Outputs are decoded from the state being entered so they are registered.
    case (state_d)
      StUpdSetup: begin
        flag_d = 1'b1;
        wrn_d  = 1'b0;
        busy_d = 1'b1;
      end
      StUpdWrite, StUpdLast: begin
        flag_d  = 1'b1;
        wrn_d   = 1'b0;
        busy_d  = 1'b1;
        ready_d = (state_d == StUpdWrite);
        if (accept) begin
          csn_d  = 1'b0;
          data_d = bus.iCoeffData;
          num_d  = idx_q;
          addr_d = sub_q;
        end else begin
          data_d = data_q;
          num_d  = num_q;
          addr_d = addr_q;
        end
      end
      StUpdEnd: begin
        done_d = 1'b1;
        busy_d = 1'b1;
      end
      StRunRead: begin
        csn_d  = 1'b0;
        addr_d = (state_q == StRunRead) ? addr_q + 4'd1 : '0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iClk_12M) begin
    if (iRst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      sub_q   <= '0;
      pend_q  <= 1'b0;
      ready_q <= 1'b0;
      flag_q  <= 1'b0;
      csn_q   <= 1'b1;
      wrn_q   <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      num_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sub_q   <= sub_d;
      pend_q  <= pend_d;
      ready_q <= ready_d;
      flag_q  <= flag_d;
      csn_q   <= csn_d;
      wrn_q   <= wrn_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      num_q   <= num_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign bus.oCoeffReady       = ready_q;
  assign bus.oCoeffiUpdateFlag = flag_q;
  assign bus.oCsnRam           = csn_q;
  assign bus.oWrnRam           = wrn_q;
  assign bus.oAddrRam          = addr_q;
  assign bus.oWrDtRam          = data_q;
  assign bus.oNumOfCoeff       = num_q;
  assign bus.oBusy             = busy_q;
  assign bus.oUpdateDone       = done_q;
  assign bus.oOverrun          = ovr_q;

endmodule
